muldiv_ctrl: RTL and testbench



---
 rtl/muldiv_ctrl_pkg.sv | 29 ++
 rtl/muldiv_ctrl_if.sv | 27 ++
 rtl/muldiv_ctrl_datapath.sv | 116 +++++++++++
 rtl/muldiv_ctrl.sv | 139 +++++++++++++
 tb/tb_muldiv_ctrl.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
// Decode uses the same MULDIV_OP_* values when it issues requests.
package muldiv_ctrl_pkg;

    // One radix-2 step per operand bit.
    localparam int MULDIV_ITERS = 32;

    typedef enum logic [2:0] {
        MULDIV_OP_MULT  = 3'd0,
        MULDIV_OP_MULTU = 3'd1,
        MULDIV_OP_DIV   = 3'd2,
        MULDIV_OP_DIVU  = 3'd3,
        MULDIV_OP_MTHI  = 3'd4,
        MULDIV_OP_MTLO  = 3'd5
    } muldiv_op_e;

    typedef enum logic [1:0] {
        MULDIV_ST_IDLE  = 2'd0,
        MULDIV_ST_MUL   = 2'd1,
        MULDIV_ST_DIV   = 2'd2,
        MULDIV_ST_FIXUP = 2'd3
    } muldiv_state_e;

    // Encodings 6 and 7 are not muldiv ops and must be ignored entirely.
    function automatic logic op_is_valid(logic [2:0] op);
        return ~(op[2] & op[1]);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Decode <-> muldiv request/read bundle. Decode is the master.
interface muldiv_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic [2:0]       req_op;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             rd_hi;
    logic             rd_lo;
    logic             abort;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output req_valid, req_op, op_a, op_b, rd_hi, rd_lo, abort,
        input  stall, busy, done, hi, lo
    );

    modport slave (
        input  req_valid, req_op, op_a, op_b, rd_hi, rd_lo, abort,
        output stall, busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_ctrl_datapath.sv
// Operand registers, WIDTH+1 adder/subtractor and shift registers for the
// iterative multiply/divide, plus the final sign correction.
// Operands are held as magnitudes; signs are re-applied at fixup.
// Build option MULDIV_FAST_MUL_EN: product comes from a single-cycle
// multiplier on the latched magnitudes instead of the shift-add registers.
module muldiv_ctrl_datapath #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             load_div,
    input  logic             load_signed,
    input  logic             step,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] fix_hi,
    output logic [WIDTH-1:0] fix_lo
);
    // acc: upper product half / partial remainder
    // sh : multiplier shifting out / quotient shifting in
    // opb: multiplicand / divisor magnitude
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   add_a, add_b, add_res;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    // Operand load and one radix-2 iteration through the shared adder.
    always_comb begin
        // NOTE: every *_d gets a default first so no path leaves it unassigned (no latch).
        acc_d     = acc_q;
        sh_d      = sh_q;
        opb_d     = opb_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;

        a_neg = load_signed & op_a[WIDTH-1];
        b_neg = load_signed & op_b[WIDTH-1];
        a_mag = a_neg ? -op_a : op_a;
        b_mag = b_neg ? -op_b : op_b;

        // Divide: trial-subtract divisor from {rem, next dividend bit}.
        // Multiply: add multiplicand when the low multiplier bit is set.
        if (is_div_q) begin
            add_a   = {acc_q, sh_q[WIDTH-1]};
            add_b   = {1'b0, opb_q};
            add_res = add_a - add_b;
        end else begin
            add_a   = {1'b0, acc_q};
            add_b   = sh_q[0] ? {1'b0, opb_q} : '0;
            add_res = add_a + add_b;
        end

        if (load) begin
            acc_d     = '0;
            sh_d      = a_mag;
            opb_d     = b_mag;
            is_div_d  = load_div;
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
        end else if (step) begin
            if (is_div_q) begin
                // Top bit of the WIDTH+1 difference is the borrow: restore on borrow.
                acc_d = add_res[WIDTH] ? add_a[WIDTH-1:0] : add_res[WIDTH-1:0];
                sh_d  = {sh_q[WIDTH-2:0], ~add_res[WIDTH]};
            end else begin
                acc_d = add_res[WIDTH:1];
                sh_d  = {add_res[0], sh_q[WIDTH-1:1]};
            end
        end
    end

    // Sign correction of the finished magnitude result.
    always_comb begin
`ifdef MULDIV_FAST_MUL_EN
        prod = {{WIDTH{1'b0}}, sh_q} * {{WIDTH{1'b0}}, opb_q};
`else
        prod = {acc_q, sh_q};
`endif
        prod_fix = neg_res_q ? -prod : prod;
        quo_fix  = neg_res_q ? -sh_q : sh_q;
        rem_fix  = neg_rem_q ? -acc_q : acc_q;
        fix_hi   = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            sh_q      <= '0;
            opb_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values together.
            acc_q     <= acc_d;
            sh_q      <= sh_d;
            opb_q     <= opb_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer for the shared multiply/divide unit and the HI/LO registers.
// Owns the FSM, iteration counter, stall/busy/done and HI/LO writes;
// arithmetic lives in muldiv_ctrl_datapath.
// Build option MULDIV_FAST_MUL_EN: multiplies skip the MUL state and
// finish one edge after accept.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = MULDIV_ITERS
) (
    input logic           clk,
    input logic           rst_n,
    muldiv_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    muldiv_state_e    state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    logic             busy;
    logic             op_ok;
    logic             accept;
    logic             dp_load, dp_step;
    logic             dp_load_div, dp_load_signed;
    logic [WIDTH-1:0] fix_hi, fix_lo;

    assign busy           = (state_q != MULDIV_ST_IDLE);
    assign op_ok          = op_is_valid(bus.req_op);
    assign accept         = bus.req_valid & op_ok & ~busy & ~bus.abort;
    assign dp_load_signed = (bus.req_op == MULDIV_OP_MULT) | (bus.req_op == MULDIV_OP_DIV);
    assign dp_load_div    = (bus.req_op == MULDIV_OP_DIV)  | (bus.req_op == MULDIV_OP_DIVU);

    // Next-state, counter and HI/LO write decisions.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dp_load = 1'b0;
        dp_step = 1'b0;

        unique case (state_q)
            MULDIV_ST_IDLE: begin
                if (accept) begin
                    case (bus.req_op)
                        MULDIV_OP_MTHI: hi_d = bus.op_a;
                        MULDIV_OP_MTLO: lo_d = bus.op_a;
                        MULDIV_OP_MULT, MULDIV_OP_MULTU: begin
                            dp_load = 1'b1;
                            count_d = '0;
`ifdef MULDIV_FAST_MUL_EN
                            state_d = MULDIV_ST_FIXUP;
`else
                            state_d = MULDIV_ST_MUL;
`endif
                        end
                        MULDIV_OP_DIV, MULDIV_OP_DIVU: begin
                            if (bus.op_b == '0) begin
                                // Divide by zero resolves immediately, no iteration.
                                hi_d   = bus.op_a;
                                lo_d   = '1;
                                done_d = 1'b1;
                            end else begin
                                dp_load = 1'b1;
                                count_d = '0;
                                state_d = MULDIV_ST_DIV;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            MULDIV_ST_MUL, MULDIV_ST_DIV: begin
                if (bus.abort) begin
                    state_d = MULDIV_ST_IDLE;
                end else begin
                    dp_step = 1'b1;
                    count_d = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(WIDTH - 1)) begin
                        state_d = MULDIV_ST_FIXUP;
                    end
                end
            end
            MULDIV_ST_FIXUP: begin
                state_d = MULDIV_ST_IDLE;
                if (!bus.abort) begin
                    hi_d   = fix_hi;
                    lo_d   = fix_lo;
                    done_d = 1'b1;
                end
            end
            default: state_d = MULDIV_ST_IDLE;
        endcase
    end

    // FSM, counter and architectural HI/LO registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MULDIV_ST_IDLE;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    muldiv_ctrl_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (dp_load),
        .load_div    (dp_load_div),
        .load_signed (dp_load_signed),
        .step        (dp_step),
        .op_a        (bus.op_a),
        .op_b        (bus.op_b),
        .fix_hi      (fix_hi),
        .fix_lo      (fix_lo)
    );

    // Stall only while busy, and only for real muldiv traffic or HI/LO reads.
    assign bus.stall = busy & ((bus.req_valid & op_ok) | bus.rd_hi | bus.rd_lo);
    assign bus.busy  = busy;
    assign bus.done  = done_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: scoreboard of expected {hi,lo}
// pushed at issue, popped on each done pulse.
// Honours MULDIV_FAST_MUL_EN for the expected multiply latency.
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = W + 1;
`endif
    localparam int DIV_LAT = W + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_ctrl_if #(.WIDTH(W)) bus ();

    muldiv_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] exp_q[$];
    int          done_cyc[$];
    int          cyc = 0;
    int          busy_cnt, done_cnt, stall_cnt;
    logic [31:0] saved_hi, saved_lo;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        longint      sa, sb, sq, sr;
        logic [63:0] ua, ub, q64, r64;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        model = '0;
        case (op)
            MULDIV_OP_MULT:  model = sa * sb;
            MULDIV_OP_MULTU: model = ua * ub;
            MULDIV_OP_DIV, MULDIV_OP_DIVU: begin
                if (b == 32'd0) begin
                    model = {a, 32'hFFFF_FFFF};
                end else if (op == MULDIV_OP_DIV) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    q64 = sq;
                    r64 = sr;
                    model = {r64[31:0], q64[31:0]};
                end else begin
                    q64 = ua / ub;
                    r64 = ua % ub;
                    model = {r64[31:0], q64[31:0]};
                end
            end
            default: model = '0;
        endcase
    endfunction

    // Sample this cycle's outputs just after the falling edge, then advance
    // one cycle. A request seen accepted is withdrawn, as decode would.
    task automatic tick();
        logic        acc;
        logic [63:0] e;
        #1;
        if (bus.done) begin
            done_cnt++;
            done_cyc.push_back(cyc);
            check("sb_has_entry_at_done", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("result_hilo", {bus.hi, bus.lo}, e);
            end
        end
        busy_cnt  += int'(bus.busy);
        stall_cnt += int'(bus.stall);
        acc = bus.req_valid & ~bus.busy & ~bus.abort;
        @(negedge clk);
        cyc++;
        if (acc) bus.req_valid = 1'b0;
    endtask

    task automatic start(logic [2:0] op, logic [31:0] a, logic [31:0] b, bit expect_res);
        busy_cnt  = 0;
        done_cnt  = 0;
        stall_cnt = 0;
        done_cyc.delete();
        bus.req_op    = op;
        bus.op_a      = a;
        bus.op_b      = b;
        bus.req_valid = 1'b1;
        if (expect_res) exp_q.push_back(model(op, a, b));
    endtask

    task automatic wait_done(int n, int budget);
        for (int i = 0; i < budget && done_cnt < n; i++) tick();
    endtask

    task automatic run_op(string tag, logic [2:0] op, logic [31:0] a, logic [31:0] b, int exp_busy);
        start(op, a, b, 1'b1);
        wait_done(1, 200);
        repeat (2) tick();
        bus.req_valid = 1'b0;
        check($sformatf("%s_busy_cycles", tag), busy_cnt, exp_busy);
        check($sformatf("%s_done_pulses", tag), done_cnt, 1);
        check($sformatf("%s_sb_drained", tag), exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        int          lat;

        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.rd_hi     = 1'b0;
        bus.rd_lo     = 1'b0;
        bus.abort     = 1'b0;
        busy_cnt = 0; done_cnt = 0; stall_cnt = 0;

        // Reset state, with a read pending to show stall stays low.
        repeat (3) @(negedge clk);
        bus.rd_hi = 1'b1;
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_stall", bus.stall, 0);
        check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        bus.rd_hi = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("multu_max", MULDIV_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);

        // MULT with MFHI held from the cycle after accept.
        start(MULDIV_OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1);
        tick();
        bus.rd_hi = 1'b1;
        wait_done(1, 200);
        repeat (2) tick();
        bus.rd_hi = 1'b0;
        check("mfhi_stall_cycles", stall_cnt, MUL_LAT);
        check("mfhi_done_pulses", done_cnt, 1);

        run_op("div_neg",      MULDIV_OP_DIV,  32'hFFFF_FFF9, 32'd2,         DIV_LAT);
        run_op("divu_100_7",   MULDIV_OP_DIVU, 32'd100,       32'd7,         DIV_LAT);
        run_op("divu_zero",    MULDIV_OP_DIVU, 32'h0000_1234, 32'd0,         0);
        run_op("div_zero_neg", MULDIV_OP_DIV,  32'h8000_0000, 32'd0,         0);
        run_op("div_ovf",      MULDIV_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT);
        run_op("divu_big",     MULDIV_OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, DIV_LAT);

        // MTHI then MTLO: written at the next edge, no stall, no done.
        saved_lo = bus.lo;
        start(MULDIV_OP_MTHI, 32'h1357_9BDF, 32'd0, 1'b0);
        tick();
        check("mthi_hi", bus.hi, 32'h1357_9BDF);
        check("mthi_lo_kept", bus.lo, saved_lo);
        start(MULDIV_OP_MTLO, 32'hA5A5_A5A5, 32'd0, 1'b0);
        tick();
        check("mtlo_lo", bus.lo, 32'hA5A5_A5A5);
        check("mtlo_hi_kept", bus.hi, 32'h1357_9BDF);
        repeat (2) tick();
        check("mt_no_busy", busy_cnt, 0);
        check("mt_no_stall", stall_cnt, 0);
        check("mt_no_done", done_cnt, 0);

        // DIV aborted part way through the iterations.
        start(MULDIV_OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        repeat (11) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_idle_next", bus.busy, 0);
        repeat (3) tick();
        check("abort_hi_kept", bus.hi, 32'h1357_9BDF);
        check("abort_lo_kept", bus.lo, 32'hA5A5_A5A5);
        check("abort_no_done", done_cnt, 0);

        // Abort together with a request in IDLE: request dropped.
        start(MULDIV_OP_MULT, 32'd5, 32'd6, 1'b0);
        bus.abort = 1'b1;
        tick();
        bus.abort     = 1'b0;
        bus.req_valid = 1'b0;
        repeat (3) tick();
        check("abort_req_no_busy", busy_cnt, 0);
        check("abort_req_no_done", done_cnt, 0);

        // Invalid op codes: never accepted, never stall.
        start(3'd6, 32'd9, 32'd3, 1'b0);
        repeat (3) tick();
        bus.req_valid = 1'b0;
        check("inv_idle_no_busy", busy_cnt, 0);
        start(MULDIV_OP_DIVU, 32'd1000, 32'd9, 1'b1);
        repeat (4) tick();
        bus.req_op    = 3'd7;
        bus.req_valid = 1'b1;
        #1;
        check("inv_busy_no_stall", bus.stall, 0);
        bus.req_valid = 1'b0;
        wait_done(1, 200);
        tick();
        check("inv_div_done", done_cnt, 1);

        // Second request while busy: stalled, then taken in the first idle cycle.
        start(MULDIV_OP_DIV, 32'd1000, 32'hFFFF_FFFD, 1'b1);
        repeat (6) tick();
        stall_cnt     = 0;
        busy_cnt      = 0;
        bus.req_op    = MULDIV_OP_MULT;
        bus.op_a      = 32'h1234_5678;
        bus.op_b      = 32'hFEDC_BA98;
        bus.req_valid = 1'b1;
        exp_q.push_back(model(MULDIV_OP_MULT, 32'h1234_5678, 32'hFEDC_BA98));
        wait_done(2, 300);
        repeat (2) tick();
        bus.req_valid = 1'b0;
        check("b2b_stall_cycles", stall_cnt, DIV_LAT - 5);
        check("b2b_busy_cycles", busy_cnt, DIV_LAT - 5 + MUL_LAT);
        check("b2b_done_pulses", done_cnt, 2);
        if (done_cyc.size() == 2)
            check("b2b_done_gap", done_cyc[1] - done_cyc[0], MUL_LAT + 1);
        check("b2b_sb_drained", exp_q.size(), 0);
        exp_q.delete();

        // Randomised ops against the model.
        for (int i = 0; i < 10; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            if (i == 4) rb = 32'd0;
            if (rop <= 3'd1)      lat = MUL_LAT;
            else if (rb == 32'd0) lat = 0;
            else                  lat = DIV_LAT;
            run_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, lat);
        end

        // Asynchronous reset in the middle of a divide.
        start(MULDIV_OP_DIV, 32'd12345, 32'd67, 1'b0);
        repeat (8) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", bus.busy, 0);
        check("arst_done", bus.done, 0);
        check("arst_hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        busy_cnt = 0;
        repeat (3) tick();
        check("arst_stays_idle", busy_cnt, 0);
        check("arst_no_done", done_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
